rv_dmem_wb_bridge: RTL

- Responder end of the core's data memory interface. The execute stage is the initiator: it drives address, store data, byte select and load/store strobes, and samples ready.
- Converts each accepted request into one Wishbone B4 pipelined single transfer.
- Returns load data and completion/error pulses to writeback, and holds ready low until the bus transfer completes.
- Sits between the core and the system interconnect.

---
 rtl/rv_dmem_wb_bridge_if.sv | 50 +++++
 rtl/rv_dmem_wb_bridge.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rv_dmem_wb_bridge_if.sv
// Bundles for rv_dmem_wb_bridge.
//   rv_dmem_if : core data-memory request/response (master = execute/writeback, slave = bridge)
//   rv_wb_if   : Wishbone B4 pipelined bus (master = bridge, slave = bus target)
// Signal names keep the bridge-side _i/_o suffixes so they read the same as the block ports.

interface rv_dmem_if;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_store_i;
  logic        dm_load_i;
  logic        dm_ready_o;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic        dm_bus_err_o;

  modport master (
    output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_store_i, dm_load_i,
    input  dm_ready_o, dm_data_l_o, dm_load_done_o, dm_store_done_o, dm_bus_err_o
  );

  modport slave (
    input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_store_i, dm_load_i,
    output dm_ready_o, dm_data_l_o, dm_load_done_o, dm_store_done_o, dm_bus_err_o
  );
endinterface

interface rv_wb_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_stall_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );
endinterface

// File: rtl/rv_dmem_wb_bridge.sv
// Data-memory responder: turns one core load/store request into one Wishbone B4
// pipelined single transfer and returns data plus done/error pulses to writeback.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   dm           : core request/response bundle (slave side)
//   wb           : Wishbone bus (master side)
// Parameters:
//   g_timeout  : cycles a bus cycle may stay open without ack/err (1..65535)
//   g_err_data : load data returned on error or timeout

module rv_dmem_wb_bridge #(
  parameter int unsigned g_timeout  = 255,
  parameter logic [31:0] g_err_data = 32'h0000_0000
) (
  input logic     clk_i,
  input logic     rst_i,
  rv_dmem_if.slave dm,
  rv_wb_if.master  wb
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_WAIT} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_ready, w_ready;
  logic             r_cyc, w_cyc;
  logic             r_stb, w_stb;
  logic             r_we, w_we;
  logic [31:0]      r_adr, w_adr;
  logic [31:0]      r_dat, w_dat;
  logic [3:0]       r_sel, w_sel;
  logic [31:0]      r_data_l, w_data_l;
  logic             r_load_done, w_load_done;
  logic             r_store_done, w_store_done;
  logic             r_bus_err, w_bus_err;
  logic [CNT_W-1:0] r_cnt, w_cnt;

  logic [CNT_W:0]   w_cnt_inc;
  logic             w_timeout;
  logic             w_fail;
  logic             w_end;

  // Count of open-cycle clocks including this one; abort once it reaches g_timeout.
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign w_timeout = (w_cnt_inc >= (CNT_W+1)'(g_timeout));
  // err wins over ack; timeout is treated as err
  assign w_fail    = wb.wb_err_i | w_timeout;
  assign w_end     = wb.wb_ack_i | w_fail;

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b1;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_dat        <= '0;
      r_sel        <= '0;
      r_data_l     <= '0;
      r_load_done  <= 1'b0;
      r_store_done <= 1'b0;
      r_bus_err    <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ready      <= w_ready;
      r_cyc        <= w_cyc;
      r_stb        <= w_stb;
      r_we         <= w_we;
      r_adr        <= w_adr;
      r_dat        <= w_dat;
      r_sel        <= w_sel;
      r_data_l     <= w_data_l;
      r_load_done  <= w_load_done;
      r_store_done <= w_store_done;
      r_bus_err    <= w_bus_err;
      r_cnt        <= w_cnt;
    end
  end

  // Next state and next output values
  always_comb begin
    w_state_nxt  = r_state;
    w_ready      = r_ready;
    w_cyc        = r_cyc;
    w_stb        = r_stb;
    w_we         = r_we;
    w_adr        = r_adr;
    w_dat        = r_dat;
    w_sel        = r_sel;
    w_data_l     = r_data_l;
    w_load_done  = 1'b0;
    w_store_done = 1'b0;
    w_bus_err    = 1'b0;
    w_cnt        = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (dm.dm_load_i || dm.dm_store_i) begin
          // Store takes priority when both strobes are high
          w_we        = dm.dm_store_i;
          w_adr       = dm.dm_addr_i & 32'hFFFF_FFFC;
          w_dat       = dm.dm_data_s_i;
          w_sel       = dm.dm_data_select_i;
          w_cyc       = 1'b1;
          w_stb       = 1'b1;
          w_ready     = 1'b0;
          w_cnt       = '0;
          w_state_nxt = ST_STROBE;
        end
      end

      ST_STROBE, ST_WAIT: begin
        w_cnt = w_cnt_inc[CNT_W-1:0];
        if ((r_state == ST_STROBE) && !wb.wb_stall_i) begin
          w_stb       = 1'b0;
          w_state_nxt = ST_WAIT;
        end
        // Ack/err may land in the strobe cycle itself
        if (w_end) begin
          w_cyc        = 1'b0;
          w_stb        = 1'b0;
          w_ready      = 1'b1;
          w_load_done  = ~r_we;
          w_store_done = r_we;
          w_state_nxt  = ST_IDLE;
          if (w_fail) begin
            w_bus_err = 1'b1;
            w_data_l  = g_err_data;
          end else if (!r_we) begin
            w_data_l  = wb.wb_dat_i;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign dm.dm_ready_o      = r_ready;
  assign dm.dm_data_l_o     = r_data_l;
  assign dm.dm_load_done_o  = r_load_done;
  assign dm.dm_store_done_o = r_store_done;
  assign dm.dm_bus_err_o    = r_bus_err;
  assign wb.wb_adr_o        = r_adr;
  assign wb.wb_dat_o        = r_dat;
  assign wb.wb_sel_o        = r_sel;
  assign wb.wb_we_o         = r_we;
  assign wb.wb_cyc_o        = r_cyc;
  assign wb.wb_stb_o        = r_stb;

endmodule
